reg_rename_file: RTL and testbench

// - Architectural register file with rename tags for the out-of-order core. Reorder-buffer side is
//   the writer: it sets dependencies at dispatch and writes values at commit.
// - Decoder side is the reader: it gets each source operand as a ready value or as a producing ROB tag.
// - Busy registers are forwarded through the ROB value-query port, so a result already finished in
//   the ROB is returned as ready.

---
 rtl/reg_rename_file.sv | 145 ++++++++++++++
 tb/tb_reg_rename_file.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// reg_rename_file
// Architectural register file with rename tags. The reorder buffer marks a
// register busy with a producer tag at dispatch and writes the value at
// commit. The decoder reads two source operands per cycle and gets either a
// ready value or the tag of the producing ROB entry. Busy operands are looked
// up through the ROB value-query port, so finished results return as ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; 0 freezes all state
//   clear             flush: all rename state dropped, values kept
//   commit_*          register write from ROB commit (valid, rd, val, rob_id)
//   dep_*             rename at dispatch (valid, rd, rob_id)
//   rs1_idx, rs2_idx  source register indices
//   rob_q1, rob_q2    producer tags sent to the ROB value query
//   rob_rdy*, rob_val* ROB query response
//   rs*_busy/val/tag  operand result (val valid when not busy, tag when busy)
//   retired_cnt       commits accepted since reset
module reg_rename_file #(
  parameter int ROB_W = 3,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [XLEN-1:0]  commit_val,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic             dep_valid,
  input  logic [4:0]       dep_rd,
  input  logic [ROB_W-1:0] dep_rob_id,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic [ROB_W-1:0] rob_q1,
  output logic [ROB_W-1:0] rob_q2,
  input  logic             rob_rdy1,
  input  logic             rob_rdy2,
  input  logic [XLEN-1:0]  rob_val1,
  input  logic [XLEN-1:0]  rob_val2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  output logic [ROB_W-1:0] rs1_tag,
  output logic [ROB_W-1:0] rs2_tag,
  output logic [31:0]      retired_cnt
);

  logic [XLEN-1:0]  val_reg [32];
  logic [ROB_W-1:0] tag_reg [32];
  logic [31:0]      busy_reg;
  logic [31:0]      retired_cnt_reg;

  // Register 0 is never written, so it keeps its reset state (0, not busy).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        val_reg[i] <= '0;
        tag_reg[i] <= '0;
      end
      busy_reg        <= '0;
      retired_cnt_reg <= '0;
    end else if (rdy) begin
      if (commit_valid) begin
        retired_cnt_reg <= retired_cnt_reg + 32'd1;
        if (commit_rd != 5'd0) begin
          val_reg[commit_rd] <= commit_val;
          // Only the most recent producer may retire the rename; an older
          // commit leaves a younger rename in place.
          if (busy_reg[commit_rd] && tag_reg[commit_rd] == commit_rob_id)
            busy_reg[commit_rd] <= 1'b0;
        end
      end
      // Placed after the commit so a same-register rename overrides the
      // busy release above.
      if (clear) begin
        busy_reg <= '0;
        for (int i = 0; i < 32; i++)
          tag_reg[i] <= '0;
      end else if (dep_valid && dep_rd != 5'd0) begin
        busy_reg[dep_rd] <= 1'b1;
        tag_reg[dep_rd]  <= dep_rob_id;
      end
    end
  end

  assign retired_cnt = retired_cnt_reg;

  // Read ports, gathered into arrays so both share one description.
  logic [4:0]       rd_idx  [2];
  logic             rd_rrdy [2];
  logic [XLEN-1:0]  rd_rval [2];
  logic [ROB_W-1:0] rd_q    [2];
  logic             rd_busy [2];
  logic [XLEN-1:0]  rd_val  [2];
  logic [ROB_W-1:0] rd_tag  [2];

  assign rd_idx[0]  = rs1_idx;
  assign rd_idx[1]  = rs2_idx;
  assign rd_rrdy[0] = rob_rdy1;
  assign rd_rrdy[1] = rob_rdy2;
  assign rd_rval[0] = rob_val1;
  assign rd_rval[1] = rob_val2;

  wire commit_fire = rdy && commit_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rd_q[gi] = tag_reg[rd_idx[gi]];

      always_comb begin
        rd_busy[gi] = 1'b0;
        rd_val[gi]  = '0;
        rd_tag[gi]  = '0;
        if (rd_idx[gi] == 5'd0) begin
          rd_val[gi] = '0;
        end else if (!busy_reg[rd_idx[gi]]) begin
          rd_val[gi] = val_reg[rd_idx[gi]];
        end else if (commit_fire && commit_rd == rd_idx[gi] &&
                     commit_rob_id == tag_reg[rd_idx[gi]]) begin
          // Producer is committing right now: forward its value.
          rd_val[gi] = commit_val;
        end else if (rd_rrdy[gi]) begin
          // The ROB was queried with this register's tag and has the result.
          rd_val[gi] = rd_rval[gi];
        end else begin
          rd_busy[gi] = 1'b1;
          rd_tag[gi]  = tag_reg[rd_idx[gi]];
        end
      end
    end
  endgenerate

  assign rob_q1   = rd_q[0];
  assign rob_q2   = rd_q[1];
  assign rs1_busy = rd_busy[0];
  assign rs2_busy = rd_busy[1];
  assign rs1_val  = rd_val[0];
  assign rs2_val  = rd_val[1];
  assign rs1_tag  = rd_tag[0];
  assign rs2_tag  = rd_tag[1];

endmodule

// File: tb/tb_reg_rename_file.sv
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0, rdy = 1'b1, clear = 1'b0;
  logic        commit_valid = 1'b0, dep_valid = 1'b0;
  logic [4:0]  commit_rd = '0, dep_rd = '0, rs1_idx = '0, rs2_idx = '0;
  logic [31:0] commit_val = '0, rob_val1 = '0, rob_val2 = '0;
  logic [2:0]  commit_rob_id = '0, dep_rob_id = '0;
  logic        rob_rdy1 = 1'b0, rob_rdy2 = 1'b0;
  logic [2:0]  rob_q1, rob_q2, rs1_tag, rs2_tag;
  logic        rs1_busy, rs2_busy;
  logic [31:0] rs1_val, rs2_val, retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_rename_file #(.ROB_W(3), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id),
    .dep_valid(dep_valid), .dep_rd(dep_rd), .dep_rob_id(dep_rob_id),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rob_q1(rob_q1), .rob_q2(rob_q2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
    .rob_val1(rob_val1), .rob_val2(rob_val2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .retired_cnt(retired_cnt)
  );

  // Reference model: architectural view of registers and their renames.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [2:0]  m_tag  [32];
  logic [31:0] m_cnt;

  function automatic void model_step();
    int crd = commit_rd;
    int drd = dep_rd;
    bit busy_was;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
      m_cnt = 0;
      return;
    end
    if (!rdy) return;
    busy_was = (crd != 0) && m_busy[crd] && (m_tag[crd] == commit_rob_id);
    if (commit_valid) begin
      m_cnt = m_cnt + 1;
      if (crd != 0) begin
        m_val[crd] = commit_val;
        if (busy_was) m_busy[crd] = 0;
      end
    end
    if (clear) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (dep_valid && drd != 0) begin
      m_busy[drd] = 1; m_tag[drd] = dep_rob_id;
    end
  endfunction

  // Expected operand for source index idx given current ROB response.
  function automatic void model_read(input logic [4:0] idx, input logic rr,
                                     input logic [31:0] rv, output logic b,
                                     output logic [31:0] v, output logic [2:0] t,
                                     output logic [2:0] q);
    b = 0; v = 0; t = 0;
    q = (idx == 0) ? 3'd0 : m_tag[idx];
    if (idx == 0) return;
    if (!m_busy[idx]) begin v = m_val[idx]; return; end
    if (rdy && commit_valid && commit_rd == idx && commit_rob_id == m_tag[idx]) begin
      v = commit_val; return;
    end
    if (rr) begin v = rv; return; end
    b = 1; t = m_tag[idx];
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1; clear = 0; commit_valid = 0; dep_valid = 0; rob_rdy1 = 0; rob_rdy2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_idx = 5; rs2_idx = 0;
    #1;
    n_tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'd0) begin
      n_fail++; $display("FAIL reset_rs1 got busy=%0d val=%h exp busy=0 val=0", rs1_busy, rs1_val); end
    n_tests++; if (rs2_busy !== 1'b0 || rs2_val !== 32'd0) begin
      n_fail++; $display("FAIL reset_rs2 got busy=%0d val=%h exp busy=0 val=0", rs2_busy, rs2_val); end
    n_tests++; if (retired_cnt !== 32'd0 || rob_q1 !== 3'd0) begin
      n_fail++; $display("FAIL reset_cnt got cnt=%0d q1=%0d exp 0 0", retired_cnt, rob_q1); end
    $display("[TB] reset: rs1=5 busy=%0d val=%h cnt=%0d", rs1_busy, rs1_val, retired_cnt);
  endtask

  task automatic test_rob_forward();
    do_reset();
    dep_valid = 1; dep_rd = 5; dep_rob_id = 2;
    tick();
    idle(); rs1_idx = 5;
    #1;
    n_tests++; if (rs1_busy !== 1'b1 || rs1_tag !== 3'd2 || rob_q1 !== 3'd2) begin
      n_fail++; $display("FAIL fwd_busy got busy=%0d tag=%0d q=%0d exp 1 2 2", rs1_busy, rs1_tag, rob_q1); end
    rob_rdy1 = 1; rob_val1 = 32'h77;
    #1;
    n_tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'h77 || rs1_tag !== 3'd0) begin
      n_fail++; $display("FAIL fwd_ready got busy=%0d val=%h tag=%0d exp 0 77 0", rs1_busy, rs1_val, rs1_tag); end
    $display("[TB] rob_forward: tag=2 rob_val=77 -> busy=%0d val=%h", rs1_busy, rs1_val);
    idle();
  endtask

  task automatic test_commit_order();
    do_reset();
    dep_valid = 1; dep_rd = 5; dep_rob_id = 2; tick();
    dep_rob_id = 3; tick();
    idle(); commit_valid = 1; commit_rd = 5; commit_rob_id = 2; commit_val = 32'h11; tick();
    idle(); rs1_idx = 5;
    #1;
    n_tests++; if (rs1_busy !== 1'b1 || rs1_tag !== 3'd3 || retired_cnt !== 32'd1) begin
      n_fail++; $display("FAIL old_commit got busy=%0d tag=%0d cnt=%0d exp 1 3 1", rs1_busy, rs1_tag, retired_cnt); end
    commit_valid = 1; commit_rob_id = 3; commit_val = 32'h22; tick();
    idle();
    #1;
    n_tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'h22 || retired_cnt !== 32'd2) begin
      n_fail++; $display("FAIL new_commit got busy=%0d val=%h cnt=%0d exp 0 22 2", rs1_busy, rs1_val, retired_cnt); end
    $display("[TB] commit_order: val=%h cnt=%0d", rs1_val, retired_cnt);
  endtask

  task automatic test_same_cycle();
    do_reset();
    dep_valid = 1; dep_rd = 7; dep_rob_id = 1; tick();
    commit_valid = 1; commit_rd = 7; commit_rob_id = 1; commit_val = 32'hAB;
    dep_valid = 1; dep_rd = 7; dep_rob_id = 0; rs1_idx = 7;
    #1;
    n_tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'hAB) begin
      n_fail++; $display("FAIL bypass got busy=%0d val=%h exp 0 ab", rs1_busy, rs1_val); end
    tick();
    idle();
    #1;
    n_tests++; if (rs1_busy !== 1'b1 || rs1_tag !== 3'd0 || rob_q1 !== 3'd0) begin
      n_fail++; $display("FAIL dep_wins got busy=%0d tag=%0d exp 1 0", rs1_busy, rs1_tag); end
    $display("[TB] same_cycle: bypass val=AB then busy=%0d tag=%0d", rs1_busy, rs1_tag);
  endtask

  task automatic test_clear();
    do_reset();
    dep_valid = 1; dep_rd = 3; dep_rob_id = 4; tick();
    dep_rd = 4; dep_rob_id = 5; tick();
    clear = 1; commit_valid = 1; commit_rd = 3; commit_rob_id = 7; commit_val = 9;
    dep_valid = 1; dep_rd = 6; dep_rob_id = 1; tick();
    idle(); rs1_idx = 3; rs2_idx = 4;
    #1;
    n_tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'd9 || rob_q1 !== 3'd0) begin
      n_fail++; $display("FAIL clear_r3 got busy=%0d val=%h q=%0d exp 0 9 0", rs1_busy, rs1_val, rob_q1); end
    n_tests++; if (rs2_busy !== 1'b0 || rs2_val !== 32'd0) begin
      n_fail++; $display("FAIL clear_r4 got busy=%0d val=%h exp 0 0", rs2_busy, rs2_val); end
    rs2_idx = 6;
    #1;
    n_tests++; if (rs2_busy !== 1'b0 || retired_cnt !== 32'd1) begin
      n_fail++; $display("FAIL clear_r6 got busy=%0d cnt=%0d exp 0 1", rs2_busy, retired_cnt); end
    rdy = 0; commit_valid = 1; commit_rd = 3; commit_val = 32'h55; dep_valid = 1; dep_rd = 3; tick();
    idle();
    #1;
    n_tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'd9 || retired_cnt !== 32'd1) begin
      n_fail++; $display("FAIL freeze got busy=%0d val=%h cnt=%0d exp 0 9 1", rs1_busy, rs1_val, retired_cnt); end
    $display("[TB] clear: r3=%h cnt=%0d", rs1_val, retired_cnt);
  endtask

  task automatic test_x0();
    do_reset();
    commit_valid = 1; commit_rd = 0; commit_val = 32'hFF; commit_rob_id = 3;
    dep_valid = 1; dep_rd = 0; dep_rob_id = 3; tick();
    idle(); rs1_idx = 0; rob_rdy1 = 1; rob_val1 = 32'h1234;
    #1;
    n_tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'd0 || rob_q1 !== 3'd0 || retired_cnt !== 32'd1) begin
      n_fail++; $display("FAIL x0 got busy=%0d val=%h q=%0d cnt=%0d exp 0 0 0 1",
                         rs1_busy, rs1_val, rob_q1, retired_cnt); end
    $display("[TB] x0: val=%h cnt=%0d", rs1_val, retired_cnt);
    idle();
  endtask

  task automatic test_random();
    logic        eb1, eb2;
    logic [31:0] ev1, ev2;
    logic [2:0]  et1, et2, eq1, eq2;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 19) == 0);
      commit_valid  = $urandom_range(0, 1);
      commit_rd     = 5'($urandom_range(0, 7));
      commit_rob_id = 3'($urandom);
      commit_val    = $urandom;
      dep_valid     = $urandom_range(0, 1);
      dep_rd        = 5'($urandom_range(0, 7));
      dep_rob_id    = 3'($urandom);
      rs1_idx       = 5'($urandom_range(0, 7));
      rs2_idx       = 5'($urandom_range(0, 7));
      rob_rdy1      = ($urandom_range(0, 3) == 0);
      rob_rdy2      = ($urandom_range(0, 3) == 0);
      rob_val1      = $urandom;
      rob_val2      = $urandom;
      #1;
      model_read(rs1_idx, rob_rdy1, rob_val1, eb1, ev1, et1, eq1);
      model_read(rs2_idx, rob_rdy2, rob_val2, eb2, ev2, et2, eq2);
      n_tests++; if (rs1_busy !== eb1 || rs1_val !== ev1 || rs1_tag !== et1 || rob_q1 !== eq1) begin
        n_fail++; $display("FAIL rand_rs1 n=%0d got %0d/%h/%0d/%0d exp %0d/%h/%0d/%0d", n,
                           rs1_busy, rs1_val, rs1_tag, rob_q1, eb1, ev1, et1, eq1); end
      n_tests++; if (rs2_busy !== eb2 || rs2_val !== ev2 || rs2_tag !== et2 || rob_q2 !== eq2) begin
        n_fail++; $display("FAIL rand_rs2 n=%0d got %0d/%h/%0d/%0d exp %0d/%h/%0d/%0d", n,
                           rs2_busy, rs2_val, rs2_tag, rob_q2, eb2, ev2, et2, eq2); end
      n_tests++; if (retired_cnt !== m_cnt) begin
        n_fail++; $display("FAIL rand_cnt n=%0d got %0d exp %0d", n, retired_cnt, m_cnt); end
      $display("[TB] rand %0d: rdy=%0d clr=%0d c=%0d/%0d d=%0d/%0d rs1=%0d busy=%0d rs2=%0d busy=%0d",
               n, rdy, clear, commit_valid, commit_rd, dep_valid, dep_rd, rs1_idx, rs1_busy,
               rs2_idx, rs2_busy);
      tick();
    end
    idle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_rob_forward();
    test_commit_order();
    test_same_cycle();
    test_clear();
    test_x0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
